// File: rtl/peripheral_inst_trace_if.sv
// Trace bus between an MSP430 core's debug taps and its instruction-trace generator.
`default_nettype none

interface peripheral_inst_trace_if #(
   parameter int CHARS = 32,
   parameter int CNT_W = 32
);
   // Raw core state, sampled by the trace generator
   logic [2:0]          i_state_code;
   logic [3:0]          e_state_code;
   logic                decode;
   logic [15:0]         pc;
   logic [15:0]         ir;
   logic                dbg_halt;

   // Human-readable trace view
   logic [8*CHARS-1:0]  i_state;
   logic [8*CHARS-1:0]  e_state;
   logic [8*CHARS-1:0]  inst_short;
   logic [8*CHARS-1:0]  inst_full;
   logic [15:0]         inst_pc;
   logic [CNT_W-1:0]    inst_number;
   logic [CNT_W-1:0]    inst_cycle;

   modport master (
      output i_state_code, e_state_code, decode, pc, ir, dbg_halt,
      input  i_state, e_state, inst_short, inst_full, inst_pc, inst_number, inst_cycle
   );

   modport slave (
      input  i_state_code, e_state_code, decode, pc, ir, dbg_halt,
      output i_state, e_state, inst_short, inst_full, inst_pc, inst_number, inst_cycle
   );
endinterface

`default_nettype wire

// File: rtl/peripheral_inst_trace.sv
// peripheral_inst_trace: turns MSP430 state codes and the decode strobe into
// registered ASCII state names, mnemonics, instruction PC and counters.
`default_nettype none

module peripheral_inst_trace #(
   parameter int CHARS = 32,
   parameter int CNT_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   peripheral_inst_trace_if.slave trc
);

   localparam int STR_W = 8 * CHARS;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef logic [STR_W-1:0] str_t;

   // Casting a string literal to STR_W zero-fills the upper bytes, which
   // yields the right-justified encoding directly.
   function automatic str_t istate_name(input logic [2:0] code);
      case (code)
         3'd0:    return STR_W'("IRQ_FETCH");
         3'd1:    return STR_W'("IRQ_DONE");
         3'd2:    return STR_W'("DEC");
         3'd3:    return STR_W'("EXT1");
         3'd4:    return STR_W'("EXT2");
         3'd5:    return STR_W'("IDLE");
         default: return STR_W'("UNKNOWN");
      endcase
   endfunction

   function automatic str_t estate_name(input logic [3:0] code);
      case (code)
         4'd0:    return STR_W'("IRQ_0");
         4'd1:    return STR_W'("IRQ_1");
         4'd2:    return STR_W'("IRQ_2");
         4'd3:    return STR_W'("IRQ_3");
         4'd4:    return STR_W'("IRQ_4");
         4'd5:    return STR_W'("SRC_AD");
         4'd6:    return STR_W'("SRC_RD");
         4'd7:    return STR_W'("SRC_WR");
         4'd8:    return STR_W'("DST_AD");
         4'd9:    return STR_W'("DST_RD");
         4'd10:   return STR_W'("DST_WR");
         4'd11:   return STR_W'("EXEC");
         4'd12:   return STR_W'("JUMP");
         4'd13:   return STR_W'("IDLE");
         default: return STR_W'("UNKNOWN");
      endcase
   endfunction

   function automatic str_t two_op_name(input logic [3:0] op);
      case (op)
         4'h4:    return STR_W'("MOV");
         4'h5:    return STR_W'("ADD");
         4'h6:    return STR_W'("ADDC");
         4'h7:    return STR_W'("SUBC");
         4'h8:    return STR_W'("SUB");
         4'h9:    return STR_W'("CMP");
         4'hA:    return STR_W'("DADD");
         4'hB:    return STR_W'("BIT");
         4'hC:    return STR_W'("BIC");
         4'hD:    return STR_W'("BIS");
         4'hE:    return STR_W'("XOR");
         4'hF:    return STR_W'("AND");
         default: return STR_W'("ILLEGAL");
      endcase
   endfunction

   function automatic str_t jump_name(input logic [2:0] cond);
      case (cond)
         3'd0:    return STR_W'("JNE");
         3'd1:    return STR_W'("JEQ");
         3'd2:    return STR_W'("JNC");
         3'd3:    return STR_W'("JC");
         3'd4:    return STR_W'("JN");
         3'd5:    return STR_W'("JGE");
         3'd6:    return STR_W'("JL");
         default: return STR_W'("JMP");
      endcase
   endfunction

   function automatic str_t one_op_name(input logic [2:0] op);
      case (op)
         3'd0:    return STR_W'("RRC");
         3'd1:    return STR_W'("SWPB");
         3'd2:    return STR_W'("RRA");
         3'd3:    return STR_W'("SXT");
         3'd4:    return STR_W'("PUSH");
         3'd5:    return STR_W'("CALL");
         3'd6:    return STR_W'("RETI");
         default: return STR_W'("ILLEGAL");
      endcase
   endfunction

   str_t             i_state_q, i_state_d;
   str_t             e_state_q, e_state_d;
   str_t             inst_short_q, inst_short_d;
   str_t             inst_full_q, inst_full_d;
   logic [15:0]      inst_pc_q, inst_pc_d;
   logic [CNT_W-1:0] inst_number_q, inst_number_d;
   logic [CNT_W-1:0] inst_cycle_q, inst_cycle_d;

   str_t             mnem;
   logic             is_byte;
   str_t             mnem_full;

   // Operand-addressing bits of ir carry no information for the mnemonic
   logic             w_unused_ir;
   assign w_unused_ir = ^trc.ir[5:0];

   always_comb begin
      mnem    = STR_W'("ILLEGAL");
      is_byte = 1'b0;
      if (trc.ir[15:12] >= 4'h4) begin
         mnem    = two_op_name(trc.ir[15:12]);
         is_byte = trc.ir[6];
      end else if (trc.ir[15:13] == 3'b001) begin
         mnem    = jump_name(trc.ir[12:10]);
      end else if (trc.ir[15:10] == 6'b000100) begin
         mnem    = one_op_name(trc.ir[9:7]);
         // Only RRC, RRA and PUSH have a byte form among single-operand ops
         is_byte = trc.ir[6] & ((trc.ir[9:7] == 3'd0) |
                                (trc.ir[9:7] == 3'd2) |
                                (trc.ir[9:7] == 3'd4));
      end
   end

   assign mnem_full = is_byte ? {mnem[STR_W-17:0], 16'h2E42} : mnem;

   always_comb begin
      i_state_d     = istate_name(trc.i_state_code);
      e_state_d     = estate_name(trc.e_state_code);
      inst_short_d  = inst_short_q;
      inst_full_d   = inst_full_q;
      inst_pc_d     = inst_pc_q;
      inst_number_d = inst_number_q;
      inst_cycle_d  = inst_cycle_q;
      if (trc.decode) begin
         inst_short_d  = mnem;
         inst_full_d   = mnem_full;
         inst_pc_d     = trc.pc;
         inst_number_d = inst_number_q + CNT_ONE;
         inst_cycle_d  = '0;
      end else if (!trc.dbg_halt) begin
         inst_cycle_d  = inst_cycle_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i_state_q     <= '0;
         e_state_q     <= '0;
         inst_short_q  <= '0;
         inst_full_q   <= '0;
         inst_pc_q     <= '0;
         inst_number_q <= '0;
         inst_cycle_q  <= '0;
      end else begin
         i_state_q     <= i_state_d;
         e_state_q     <= e_state_d;
         inst_short_q  <= inst_short_d;
         inst_full_q   <= inst_full_d;
         inst_pc_q     <= inst_pc_d;
         inst_number_q <= inst_number_d;
         inst_cycle_q  <= inst_cycle_d;
      end
   end

   assign trc.i_state     = i_state_q;
   assign trc.e_state     = e_state_q;
   assign trc.inst_short  = inst_short_q;
   assign trc.inst_full   = inst_full_q;
   assign trc.inst_pc     = inst_pc_q;
   assign trc.inst_number = inst_number_q;
   assign trc.inst_cycle  = inst_cycle_q;

endmodule

`default_nettype wire
